// File: rtl/div_unit_if.sv
// Request/response bundle between the register-file read side and the divider.
// The master issues operands and start; the slave returns status and results.
interface div_unit_if;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring 32-bit divider (DIV/DIVU), one quotient bit per clock,
// fixed 32-cycle iteration with registered quotient/remainder/div_by_zero.
module div_unit (
    input  logic       clk,
    input  logic       rst_n,
    div_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [32:0] prem_q, prem_d;
    logic [31:0] dvd_q, dvd_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] orig_q, orig_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        dz_q, dz_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] rem_q, rem_d;
    logic        dzo_q, dzo_d;

    logic [31:0] abs_dvd_s, abs_dvs_s;
    logic [33:0] shift_s, trial_s;
    logic [31:0] qraw_s, rraw_s;

    // Operand magnitudes; raw patterns are kept for unsigned requests.
    always_comb begin
        if (bus.is_signed && bus.dividend[31]) begin
            abs_dvd_s = ~bus.dividend + 32'd1;
        end else begin
            abs_dvd_s = bus.dividend;
        end
        if (bus.is_signed && bus.divisor[31]) begin
            abs_dvs_s = ~bus.divisor + 32'd1;
        end else begin
            abs_dvs_s = bus.divisor;
        end
    end

    // One restoring step; the extra top bit makes the trial sign unambiguous
    // even for divisors >= 0x80000000.
    always_comb begin
        shift_s = {prem_q, dvd_q[31]};
        trial_s = shift_s - {2'b00, dvs_q};
    end

    // Next-state, datapath update and result write-back.
    always_comb begin
        state_d = state_q;
        prem_d  = prem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        orig_d  = orig_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dzo_d   = dzo_q;
        qraw_s  = 32'd0;
        rraw_s  = 32'd0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    dvd_d   = abs_dvd_s;
                    dvs_d   = abs_dvs_s;
                    orig_d  = bus.dividend;
                    qneg_d  = bus.is_signed & (bus.dividend[31] ^ bus.divisor[31]);
                    rneg_d  = bus.is_signed & bus.dividend[31];
                    dz_d    = (bus.divisor == 32'd0);
                    cnt_d   = 6'd0;
                    prem_d  = 33'd0;
                    state_d = S_RUN;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (trial_s[33]) begin
                    prem_d = shift_s[32:0];
                    dvd_d  = {dvd_q[30:0], 1'b0};
                end else begin
                    prem_d = trial_s[32:0];
                    dvd_d  = {dvd_q[30:0], 1'b1};
                end
                cnt_d  = cnt_q + 6'd1;
                qraw_s = dvd_d;
                rraw_s = prem_d[31:0];
                if (cnt_q == 6'd31) begin
                    state_d = S_DONE;
                    if (dz_q) begin
                        quot_d = 32'hFFFF_FFFF;
                        rem_d  = orig_q;
                        dzo_d  = 1'b1;
                    end else begin
                        quot_d = qneg_q ? (~qraw_s + 32'd1) : qraw_s;
                        rem_d  = rneg_q ? (~rraw_s + 32'd1) : rraw_s;
                        dzo_d  = 1'b0;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            prem_q  <= 33'd0;
            dvd_q   <= 32'd0;
            dvs_q   <= 32'd0;
            orig_q  <= 32'd0;
            cnt_q   <= 6'd0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            quot_q  <= 32'd0;
            rem_q   <= 32'd0;
            dzo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prem_q  <= prem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            orig_q  <= orig_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dzo_q   <= dzo_d;
        end
    end

    assign bus.busy        = (state_q == S_RUN);
    assign bus.done        = (state_q == S_DONE);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dzo_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed plus random checks of div_unit against a plain-arithmetic
// reference of DIV/DIVU semantics, latency and reset behaviour.
module tb_div_unit;

    logic clk;
    logic rst_n;
    div_unit_if dif();

    int checks = 0;
    int passes = 0;

    div_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic dz);
        dz = 1'b0;
        if (b == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            r  = a;
            dz = 1'b1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (s) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: got %h, want %h", tag, got, exp);
    endtask

    task automatic start_op(input bit s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        dif.start     = 1'b1;
        dif.is_signed = s;
        dif.dividend  = a;
        dif.divisor   = b;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        check("accept_busy", {31'd0, dif.busy}, 32'd1);
        check("accept_done", {31'd0, dif.done}, 32'd0);
    endtask

    // Waits for done (bounded) and checks latency, busy coverage and results.
    task automatic wait_done(input int n0, input bit s, input logic [31:0] a,
                             input logic [31:0] b, input string tag);
        int n = n0;
        int nb = 0;
        logic [31:0] eq, er;
        logic edz;
        ref_div(s, a, b, eq, er, edz);
        while (dif.done !== 1'b1 && n < 40) begin
            if (dif.busy !== 1'b1) nb++;
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd32);
        check({tag, "_busy_gap"}, 32'(nb), 32'd0);
        check({tag, "_busy_at_done"}, {31'd0, dif.busy}, 32'd0);
        check({tag, "_q"}, dif.quotient, eq);
        check({tag, "_r"}, dif.remainder, er);
        check({tag, "_dz"}, {31'd0, dif.div_by_zero}, {31'd0, edz});
    endtask

    task automatic run_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        logic [31:0] eq, er;
        logic edz;
        start_op(s, a, b);
        wait_done(0, s, a, b, tag);
        ref_div(s, a, b, eq, er, edz);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, {31'd0, dif.done}, 32'd0);
        check({tag, "_q_hold"}, dif.quotient, eq);
    endtask

    initial begin
        int seen;
        bit s;
        logic [31:0] a, b;
        dif.start     = 1'b0;
        dif.is_signed = 1'b0;
        dif.dividend  = 32'd0;
        dif.divisor   = 32'd0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, dif.busy}, 32'd0);
        check("rst_done", {31'd0, dif.done}, 32'd0);
        check("rst_q", dif.quotient, 32'd0);
        check("rst_r", dif.remainder, 32'd0);
        check("rst_dz", {31'd0, dif.div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(1'b0, 32'd100, 32'd7, "u100_7");
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, "sm7_2");
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, "s7_m2");
        run_op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, "sm7_m2");
        run_op(1'b0, 32'hFFFF_FFFF, 32'h8000_0000, "u_bigdiv");
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "s_ovf");
        run_op(1'b0, 32'h0000_1234, 32'd0, "u_dz");
        run_op(1'b1, 32'd9, 32'd3, "clr_dz");
        run_op(1'b1, 32'h0000_1234, 32'd0, "s_dz");

        // Start during RUN is ignored; start in the done cycle is taken.
        start_op(1'b0, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = 32'd50;
        dif.divisor  = 32'd5;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        wait_done(10, 1'b0, 32'd100, 32'd7, "ign_busy");
        start_op(1'b0, 32'd10, 32'd0);
        wait_done(0, 1'b0, 32'd10, 32'd0, "b2b_dz");
        run_op(1'b0, 32'd55, 32'd6, "after_b2b");

        // Asynchronous reset in the middle of RUN.
        start_op(1'b0, 32'd1000, 32'd3);
        repeat (14) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, dif.busy}, 32'd0);
        check("mid_rst_done", {31'd0, dif.done}, 32'd0);
        check("mid_rst_q", dif.quotient, 32'd0);
        check("mid_rst_r", dif.remainder, 32'd0);
        check("mid_rst_dz", {31'd0, dif.div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (dif.done === 1'b1 || dif.busy === 1'b1) seen++;
        end
        check("mid_rst_no_done", 32'(seen), 32'd0);
        run_op(1'b1, 32'hFFFF_FC18, 32'd7, "post_rst");

        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       a = 32'h8000_0000;
                1:       a = 32'($urandom_range(0, 255));
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                3:       b = 32'h8000_0000;
                default: b = $urandom;
            endcase
            run_op(s, a, b, "rnd");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
